// File: rtl/dcache_coh_state_array_pkg.sv
// Shared types for the L1 data cache coherence state store: per-line state
// record and the dirty-scan FSM encoding.
package std_cache_pkg;

   typedef struct packed {
      logic valid;
      logic dirty;
      logic shared;
   } line_state_t;

   typedef enum logic [1:0] {
      SCAN_IDLE = 2'd0,
      SCAN_SCAN = 2'd1,
      SCAN_EMIT = 2'd2,
      SCAN_DONE = 2'd3
   } scan_state_e;

endpackage

// File: rtl/dcache_coh_state_array_if.sv
// Requester/scan bus of the coherence state store. The master side is the
// cache control logic; the slave side is dcache_coh_state_array.
interface dcache_coh_state_array_if #(
   parameter int NR_WAYS  = 8,
   parameter int NR_SETS  = 256,
   parameter int NR_PORTS = 5
);
   import std_cache_pkg::*;

   localparam int SET_W = $clog2(NR_SETS);
   localparam int WAY_W = $clog2(NR_WAYS);

   logic [NR_PORTS-1:0]              req_i;
   logic [NR_PORTS-1:0]              gnt_o;
   logic [NR_PORTS-1:0]              we_i;
   logic [NR_PORTS-1:0][SET_W-1:0]   set_i;
   logic [NR_PORTS-1:0][NR_WAYS-1:0] way_be_i;
   line_state_t [NR_PORTS-1:0]       wstate_i;
   logic [NR_PORTS-1:0]              rvalid_o;
   line_state_t [NR_WAYS-1:0]        rstate_o;

   logic             scan_req_i;
   logic             scan_inval_i;
   logic             scan_valid_o;
   logic             scan_ready_i;
   logic [SET_W-1:0] scan_set_o;
   logic [WAY_W-1:0] scan_way_o;
   logic             scan_done_o;
   logic             busy_o;

   modport master (
      output req_i, we_i, set_i, way_be_i, wstate_i,
      output scan_req_i, scan_inval_i, scan_ready_i,
      input  gnt_o, rvalid_o, rstate_o,
      input  scan_valid_o, scan_set_o, scan_way_o, scan_done_o, busy_o
   );

   modport slave (
      input  req_i, we_i, set_i, way_be_i, wstate_i,
      input  scan_req_i, scan_inval_i, scan_ready_i,
      output gnt_o, rvalid_o, rstate_o,
      output scan_valid_o, scan_set_o, scan_way_o, scan_done_o, busy_o
   );

endinterface

// File: rtl/dcache_coh_state_array_scan.sv
// Dirty-line scan engine: walks every set, reports dirty ways one at a time and
// cleans them. Invalidate-on-scan exists only with DCACHE_SCAN_INVAL_EN defined.
module dcache_state_scan
   import std_cache_pkg::*;
#(
   parameter int  NR_WAYS = 8,
   parameter int  NR_SETS = 256,
   localparam int SET_W   = $clog2(NR_SETS),
   localparam int WAY_W   = $clog2(NR_WAYS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      scan_req_i,
   input  logic                      scan_inval_i,
   input  logic                      scan_ready_i,
   input  line_state_t [NR_WAYS-1:0] row_i,
   output logic [SET_W-1:0]          cnt_o,
   output logic                      we_o,
   output line_state_t [NR_WAYS-1:0] wrow_o,
   output logic                      arb_en_o,
   output logic                      scan_valid_o,
   output logic [SET_W-1:0]          scan_set_o,
   output logic [WAY_W-1:0]          scan_way_o,
   output logic                      scan_done_o,
   output logic                      busy_o
);

   localparam logic [1:0] ST_IDLE = SCAN_IDLE;
   localparam logic [1:0] ST_SCAN = SCAN_SCAN;
   localparam logic [1:0] ST_EMIT = SCAN_EMIT;
   localparam logic [1:0] ST_DONE = SCAN_DONE;

   logic [1:0]         state_q, state_d;
   logic [SET_W-1:0]   cnt_q, cnt_d;
   logic [NR_WAYS-1:0] dirty;
   logic [NR_WAYS-1:0] rem_dirty;
   logic [WAY_W-1:0]   first_way;
   logic               last_set;

`ifdef DCACHE_SCAN_INVAL_EN
   logic inval_q, inval_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) inval_q <= 1'b0;
      else       inval_q <= inval_d;
   end
`else
   logic inval_q;
   logic unused_inval;
   assign inval_q      = 1'b0;
   assign unused_inval = scan_inval_i;
`endif

   for (genvar gi = 0; gi < NR_WAYS; gi++) begin : g_dirty
      assign dirty[gi] = row_i[gi].dirty;
   end

   // Lowest-index dirty way wins; rem_dirty tells whether EMIT must repeat.
   always_comb begin
      first_way = '0;
      for (int w = NR_WAYS - 1; w >= 0; w--) begin
         if (dirty[w]) first_way = WAY_W'(w);
      end
      rem_dirty = dirty;
      rem_dirty[first_way] = 1'b0;
   end

   assign last_set = (cnt_q == SET_W'(NR_SETS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_o    = 1'b0;
      wrow_o  = row_i;
`ifdef DCACHE_SCAN_INVAL_EN
      inval_d = inval_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (scan_req_i) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
`ifdef DCACHE_SCAN_INVAL_EN
               inval_d = scan_inval_i;
`endif
            end
         end
         ST_SCAN: begin
            if (inval_q) begin
               we_o = 1'b1;
               for (int w = 0; w < NR_WAYS; w++) begin
                  if (!dirty[w]) wrow_o[w] = '0;
               end
            end
            if (|dirty)        state_d = ST_EMIT;
            else if (last_set) state_d = ST_DONE;
            else               cnt_d   = cnt_q + SET_W'(1);
         end
         ST_EMIT: begin
            if (scan_ready_i) begin
               we_o = 1'b1;
               wrow_o[first_way].dirty = 1'b0;
               if (inval_q) wrow_o[first_way] = '0;
               if (!(|rem_dirty)) begin
                  if (last_set) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_SCAN;
                     cnt_d   = cnt_q + SET_W'(1);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A pending scan request outranks the requester ports in the start cycle.
   assign arb_en_o     = (state_q == ST_IDLE) && !scan_req_i;
   assign cnt_o        = cnt_q;
   assign scan_valid_o = (state_q == ST_EMIT);
   assign scan_set_o   = scan_valid_o ? cnt_q : '0;
   assign scan_way_o   = scan_valid_o ? first_way : '0;
   assign scan_done_o  = (state_q == ST_DONE);
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/dcache_coh_state_array.sv
// Per-line valid/dirty/shared store with fixed-priority ports and a dirty scan
// (scan invalidation enabled by DCACHE_SCAN_INVAL_EN).
module dcache_coh_state_array
   import std_cache_pkg::*;
#(
   parameter int NR_WAYS  = 8,
   parameter int NR_SETS  = 256,
   parameter int NR_PORTS = 5
) (
   input logic                      clk_i,
   input logic                      rst_i,
   dcache_coh_state_array_if.slave  bus
);

   localparam int SET_W = $clog2(NR_SETS);

   line_state_t [NR_WAYS-1:0] mem_q [NR_SETS];
   line_state_t [NR_WAYS-1:0] rstate_q, rstate_d;
   logic [NR_PORTS-1:0]       rvalid_q, rvalid_d;
   logic [NR_PORTS-1:0]       gnt_d;
   logic                      gnt_found;

   logic [SET_W-1:0]          host_set;
   logic [NR_WAYS-1:0]        host_be;
   line_state_t               host_state;
   logic                      host_wr, host_rd;

   logic                      arb_en;
   logic [SET_W-1:0]          scan_cnt;
   logic                      scan_we;
   line_state_t [NR_WAYS-1:0] scan_wrow;

   logic                      wr_en_d;
   logic [SET_W-1:0]          wr_set_d;
   line_state_t [NR_WAYS-1:0] wr_row_d;

   always_comb begin
      gnt_d     = '0;
      gnt_found = 1'b0;
      if (arb_en) begin
         for (int p = 0; p < NR_PORTS; p++) begin
            if (bus.req_i[p] && !gnt_found) begin
               gnt_d[p]  = 1'b1;
               gnt_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      host_set   = '0;
      host_be    = '0;
      host_state = '0;
      for (int p = 0; p < NR_PORTS; p++) begin
         if (gnt_d[p]) begin
            host_set   = bus.set_i[p];
            host_be    = bus.way_be_i[p];
            host_state = bus.wstate_i[p];
         end
      end
      host_wr = |(gnt_d & bus.we_i);
      host_rd = |(gnt_d & ~bus.we_i);
   end

   // Scan writes never collide with host writes since ports are not granted
   // outside IDLE; giving the scan precedence keeps that explicit.
   always_comb begin
      wr_en_d  = 1'b0;
      wr_set_d = host_set;
      wr_row_d = mem_q[host_set];
      if (scan_we) begin
         wr_en_d  = 1'b1;
         wr_set_d = scan_cnt;
         wr_row_d = scan_wrow;
      end else if (host_wr) begin
         wr_en_d = 1'b1;
         for (int w = 0; w < NR_WAYS; w++) begin
            if (host_be[w]) wr_row_d[w] = host_state;
         end
      end
      rstate_d = host_rd ? mem_q[host_set] : rstate_q;
      rvalid_d = gnt_d & ~bus.we_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NR_SETS; s++) mem_q[s] <= '0;
         rstate_q <= '0;
         rvalid_q <= '0;
      end else begin
         if (wr_en_d) mem_q[wr_set_d] <= wr_row_d;
         rstate_q <= rstate_d;
         rvalid_q <= rvalid_d;
      end
   end

   dcache_state_scan #(
      .NR_WAYS (NR_WAYS),
      .NR_SETS (NR_SETS)
   ) u_scan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .scan_req_i   (bus.scan_req_i),
      .scan_inval_i (bus.scan_inval_i),
      .scan_ready_i (bus.scan_ready_i),
      .row_i        (mem_q[scan_cnt]),
      .cnt_o        (scan_cnt),
      .we_o         (scan_we),
      .wrow_o       (scan_wrow),
      .arb_en_o     (arb_en),
      .scan_valid_o (bus.scan_valid_o),
      .scan_set_o   (bus.scan_set_o),
      .scan_way_o   (bus.scan_way_o),
      .scan_done_o  (bus.scan_done_o),
      .busy_o       (bus.busy_o)
   );

   assign bus.gnt_o    = gnt_d;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rstate_o = rstate_q;

endmodule

// File: tb/tb_dcache_coh_state_array.sv
// Directed bench for dcache_coh_state_array: reads are scoreboarded against a
// line-state model; scan reports, timing and reset abort are checked inline.
module tb_dcache_coh_state_array;
   import std_cache_pkg::*;

   localparam int NR_WAYS  = 8;
   localparam int NR_SETS  = 256;
   localparam int NR_PORTS = 5;
   localparam int ROW_W    = 3 * NR_WAYS;
`ifdef DCACHE_SCAN_INVAL_EN
   localparam bit INVAL_EN = 1'b1;
`else
   localparam bit INVAL_EN = 1'b0;
`endif

   typedef struct {
      int               port;
      logic [ROW_W-1:0] row;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_coh_state_array_if #(
      .NR_WAYS (NR_WAYS), .NR_SETS (NR_SETS), .NR_PORTS (NR_PORTS)
   ) bus ();

   dcache_coh_state_array #(
      .NR_WAYS (NR_WAYS), .NR_SETS (NR_SETS), .NR_PORTS (NR_PORTS)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   logic [2:0] model [NR_SETS][NR_WAYS];
   exp_t       sb [$];
   int         n_total = 0;
   int         n_pass  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [ROW_W-1:0] model_row(input int s);
      logic [ROW_W-1:0] r;
      for (int w = 0; w < NR_WAYS; w++) r[3*w +: 3] = model[s][w];
      return r;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < NR_SETS; s++)
         for (int w = 0; w < NR_WAYS; w++) model[s][w] = 3'b000;
   endtask

   // Advance one cycle and pop the scoreboard whenever a read result shows up.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (bus.rvalid_o != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", 64'(bus.rvalid_o), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rvalid_port", 64'(bus.rvalid_o), 64'(1 << e.port));
            chk("rstate", 64'(bus.rstate_o), 64'(e.row));
            $display("read  port %0d rstate %h", e.port, bus.rstate_o);
         end
      end
   endtask

   task automatic rd(input int p, input int s);
      bus.req_i[p] = 1'b1;
      bus.we_i[p]  = 1'b0;
      bus.set_i[p] = 8'(s);
      sb.push_back('{port: p, row: model_row(s)});
      tick();
      bus.req_i[p] = 1'b0;
   endtask

   task automatic wr(input int p, input int s, input logic [7:0] be, input logic [2:0] st);
      bus.req_i[p]    = 1'b1;
      bus.we_i[p]     = 1'b1;
      bus.set_i[p]    = 8'(s);
      bus.way_be_i[p] = be;
      bus.wstate_i[p] = st;
      for (int w = 0; w < NR_WAYS; w++) if (be[w]) model[s][w] = st;
      tick();
      $display("write port %0d set %0d be %h state %b", p, s, be, st);
      bus.req_i[p] = 1'b0;
      bus.we_i[p]  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_gnt"},        64'(bus.gnt_o), 64'd0);
      chk({pfx, "_rvalid"},     64'(bus.rvalid_o), 64'd0);
      chk({pfx, "_rstate"},     64'(bus.rstate_o), 64'd0);
      chk({pfx, "_scan_valid"}, 64'(bus.scan_valid_o), 64'd0);
      chk({pfx, "_scan_set"},   64'(bus.scan_set_o), 64'd0);
      chk({pfx, "_scan_way"},   64'(bus.scan_way_o), 64'd0);
      chk({pfx, "_scan_done"},  64'(bus.scan_done_o), 64'd0);
      chk({pfx, "_busy"},       64'(bus.busy_o), 64'd0);
   endtask

   initial begin
      int         cyc;
      int         done_cyc;
      int         n_rep;
      int         gnt_bad;
      int         k;
      logic [10:0] rep [4];

      bus.req_i = '0; bus.we_i = '0; bus.set_i = '0; bus.way_be_i = '0;
      bus.wstate_i = '0; bus.scan_req_i = 1'b0; bus.scan_inval_i = 1'b0;
      bus.scan_ready_i = 1'b0;
      model_clear();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Plain read of untouched state.
      rd(2, 5);

      // Two simultaneous requesters: lower index first, then the other.
      bus.req_i[1] = 1'b1; bus.we_i[1] = 1'b0; bus.set_i[1] = 8'd9;
      bus.req_i[3] = 1'b1; bus.we_i[3] = 1'b0; bus.set_i[3] = 8'd11;
      #1;
      chk("gnt_prio", 64'(bus.gnt_o), 64'b00010);
      sb.push_back('{port: 1, row: model_row(9)});
      tick();
      bus.req_i[1] = 1'b0;
      #1;
      chk("gnt_next", 64'(bus.gnt_o), 64'b01000);
      sb.push_back('{port: 3, row: model_row(11)});
      tick();
      bus.req_i[3] = 1'b0;

      // Byte-enabled write then immediate read of the same set.
      wr(0, 7, 8'h05, 3'b110);
      rd(1, 7);

      // Scan setup: set 7 clean, set 3 ways 1/6 dirty and way 0 clean+shared.
      wr(0, 7, 8'h05, 3'b100);
      wr(0, 3, 8'h42, 3'b110);
      wr(0, 3, 8'h01, 3'b101);

      bus.scan_inval_i = 1'b1;
      bus.scan_ready_i = 1'b1;
      bus.scan_req_i   = 1'b1;
      bus.req_i[4] = 1'b1; bus.we_i[4] = 1'b0; bus.set_i[4] = 8'd3;
      #1;
      chk("gnt_scan_start", 64'(bus.gnt_o), 64'd0);
      cyc = 1; done_cyc = 0; n_rep = 0; gnt_bad = 0;
      tick();
      cyc = 2;
      bus.scan_req_i = 1'b0;
      while (cyc < 2000) begin
         if (bus.scan_valid_o && bus.scan_ready_i) begin
            $display("scan report set %0d way %0d", bus.scan_set_o, bus.scan_way_o);
            if (n_rep < 4) rep[n_rep] = {bus.scan_set_o, bus.scan_way_o};
            n_rep++;
         end
         if (bus.gnt_o != '0) gnt_bad++;
         if (bus.scan_done_o) begin
            done_cyc = cyc;
            break;
         end
         tick();
         cyc++;
      end
      chk("scan_done_cycle", 64'(done_cyc), 64'(1 + NR_SETS + 2 + 1));
      chk("scan_nrep", 64'(n_rep), 64'd2);
      chk("scan_rep0", 64'(rep[0]), {53'd0, 8'd3, 3'd1});
      chk("scan_rep1", 64'(rep[1]), {53'd0, 8'd3, 3'd6});
      chk("gnt_during_scan", 64'(gnt_bad), 64'd0);

      for (int s = 0; s < NR_SETS; s++)
         for (int w = 0; w < NR_WAYS; w++)
            model[s][w] = INVAL_EN ? 3'b000 : (model[s][w] & 3'b101);

      tick();
      chk("gnt_after_done", 64'(bus.gnt_o), 64'b10000);
      chk("busy_after_done", 64'(bus.busy_o), 64'd0);
      sb.push_back('{port: 4, row: model_row(3)});
      tick();
      bus.req_i[4] = 1'b0;
      bus.scan_inval_i = 1'b0;
      rd(0, 7);

      // Back-pressured report, then reset in the middle of EMIT.
      wr(0, 10, 8'h04, 3'b110);
      bus.scan_ready_i = 1'b0;
      bus.scan_req_i   = 1'b1;
      tick();
      bus.scan_req_i = 1'b0;
      k = 0;
      while (!bus.scan_valid_o && k < 1000) begin
         tick();
         k++;
      end
      chk("emit_reached", 64'(bus.scan_valid_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("stall_hold", 64'({bus.scan_valid_o, bus.scan_set_o, bus.scan_way_o}),
             64'({1'b1, 8'd10, 3'd2}));
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      model_clear();
      #2;
      rst = 1'b0;
      repeat (3) tick();
      chk("post_abort_busy", 64'(bus.busy_o), 64'd0);
      chk("post_abort_valid", 64'(bus.scan_valid_o), 64'd0);
      rd(3, 10);
      tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
